// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file read side: sizes, fetch FSM states
// and one-hot helpers used by the scoreboard and the operand mux.
package regfile_pkg;

  localparam int WIDTH = 16;
  localparam int NREGS = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic logic [NREGS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = NREGS'(1) << idx;
  endfunction

  function automatic logic is_onehot(input logic [NREGS-1:0] v);
    is_onehot = (v != '0) && ((v & (v - NREGS'(1))) == '0);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: one bit per register with a write outstanding.
// Only a single-bit write-back enable clears; a set in the same cycle wins.
module reg_scoreboard
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [NREGS-1:0] wb_en,
  output logic [NREGS-1:0] clr_mask,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_q, busy_d;

  always_comb begin
    clr_mask = is_onehot(wb_en) ? wb_en : '0;
    busy_d   = busy_q & ~clr_mask;
    if (set_en) begin
      busy_d = busy_d | onehot(set_idx);
    end else begin
      busy_d = busy_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads two sources from the register file, stalls on RAW hazards
// against the busy scoreboard and forwards write-back data as it arrives.
module operand_fetch
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] rs1,
  input  logic [IDX_W-1:0] rs2,
  input  logic [IDX_W-1:0] rd,
  input  logic             rd_we,
  input  logic [WIDTH-1:0] q0,
  input  logic [WIDTH-1:0] q1,
  input  logic [WIDTH-1:0] q2,
  input  logic [WIDTH-1:0] q3,
  input  logic [WIDTH-1:0] q4,
  input  logic [WIDTH-1:0] q5,
  input  logic [WIDTH-1:0] q6,
  input  logic [WIDTH-1:0] q7,
  input  logic [NREGS-1:0] reg_en,
  input  logic [WIDTH-1:0] ALU_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [IDX_W-1:0] out_rd,
  output logic             out_rd_we,
  output logic [NREGS-1:0] busy,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d, out_rd_q, out_rd_d;
  logic             rd_we_q, rd_we_d, out_rd_we_q, out_rd_we_d;
  logic             out_valid_q, out_valid_d, in_ready_q, in_ready_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, src_a, src_b;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [NREGS-1:0] clr_mask;
  logic             blk_a, blk_b, sb_set;
  logic [WIDTH-1:0] qv [NREGS];

  assign qv[0] = q0;
  assign qv[1] = q1;
  assign qv[2] = q2;
  assign qv[3] = q3;
  assign qv[4] = q4;
  assign qv[5] = q5;
  assign qv[6] = q6;
  assign qv[7] = q7;

  reg_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set),
    .set_idx  (rd_q),
    .wb_en    (reg_en),
    .clr_mask (clr_mask),
    .busy     (busy)
  );

  always_comb begin
    // A source waiting on a write is released by that same cycle's write-back.
    blk_a = busy[rs1_q] & ~clr_mask[rs1_q];
    blk_b = busy[rs2_q] & ~clr_mask[rs2_q];
    src_a = (reg_en == onehot(rs1_q)) ? ALU_result : qv[rs1_q];
    src_b = (reg_en == onehot(rs2_q)) ? ALU_result : qv[rs2_q];

    state_d     = state_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    out_valid_d = out_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    out_rd_d    = out_rd_q;
    out_rd_we_d = out_rd_we_q;
    stall_d     = stall_q;
    sb_set      = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rs1_d   = rs1;
          rs2_d   = rs2;
          rd_d    = rd;
          rd_we_d = rd_we;
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (blk_a || blk_b) begin
          if (stall_q != '1) begin
            stall_d = stall_q + CNT_W'(1);
          end else begin
            stall_d = stall_q;
          end
        end else begin
          op_a_d      = src_a;
          op_b_d      = src_b;
          out_rd_d    = rd_q;
          out_rd_we_d = rd_we_q;
          out_valid_d = 1'b1;
          sb_set      = rd_we_q;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
      out_valid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      out_rd_q    <= '0;
      out_rd_we_q <= 1'b0;
      stall_q     <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      out_valid_q <= out_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      out_rd_q    <= out_rd_d;
      out_rd_we_q <= out_rd_we_d;
      stall_q     <= stall_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign out_rd    = out_rd_q;
  assign out_rd_we = out_rd_we_q;
  assign stall_cnt = stall_q;

endmodule
